// File: rtl/axis_pkt_checksum.sv
// axis_pkt_checksum: byte-wide AXI-Stream pass-through that can append a
// two's-complement checksum byte to the end of each packet.
//
// Optional build macro: PKT_CNT_EN adds the pkt_count output and its counter.
//
// Parameters
//   CSUM_INIT      initial value of the running byte sum at each packet start
// Ports
//   aclk           clock, rising edge
//   aresetn        asynchronous active-low reset
//   s_axis_*       upstream stream (tdata/tvalid/tlast in, tready out)
//   m_axis_*       downstream stream (tdata/tvalid/tlast out, tready in)
//   csum_en        append a checksum to packets that start while high
//   pkt_count      completed output packets (PKT_CNT_EN only)
module axis_pkt_checksum #(
   parameter logic [7:0] CSUM_INIT = 8'h00
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   input  logic        csum_en
`ifdef PKT_CNT_EN
   ,
   output logic [15:0] pkt_count
`endif
);

   typedef enum logic {StPass = 1'b0, StAppend = 1'b1} state_e;

   state_e     state_q;
   logic [7:0] data_q;
   logic       valid_q;
   logic       last_q;
   logic [7:0] sum_q;
   logic       sop_q;
   logic       en_q;

   logic       out_free;
   logic       accept;
   logic       eff_en;
   logic [7:0] sum_add;

   // Output register can take a new beat when empty or being drained this cycle.
   assign out_free      = !valid_q || m_axis_tready;
   assign s_axis_tready = (state_q == StPass) && out_free;
   assign accept        = s_axis_tvalid && s_axis_tready;
   // On the first beat of a packet the live csum_en decides; afterwards the latched copy.
   assign eff_en        = sop_q ? csum_en : en_q;
   assign sum_add       = sum_q + s_axis_tdata;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StPass;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         sum_q   <= CSUM_INIT;
         sop_q   <= 1'b1;
         en_q    <= 1'b0;
      end else begin
         if (out_free) begin
            valid_q <= 1'b0;
         end
         unique case (state_q)
            StPass: begin
               if (accept) begin
                  data_q  <= s_axis_tdata;
                  valid_q <= 1'b1;
                  if (sop_q) begin
                     en_q <= csum_en;
                  end
                  if (s_axis_tlast && eff_en) begin
                     // Hold back tlast; the checksum beat will carry it.
                     last_q  <= 1'b0;
                     sum_q   <= sum_add;
                     sop_q   <= 1'b0;
                     state_q <= StAppend;
                  end else if (s_axis_tlast) begin
                     last_q <= 1'b1;
                     sum_q  <= CSUM_INIT;
                     sop_q  <= 1'b1;
                  end else begin
                     last_q <= 1'b0;
                     sum_q  <= sum_add;
                     sop_q  <= 1'b0;
                  end
               end
            end
            StAppend: begin
               if (out_free) begin
                  data_q  <= ~sum_q + 8'd1;
                  last_q  <= 1'b1;
                  valid_q <= 1'b1;
                  sum_q   <= CSUM_INIT;
                  sop_q   <= 1'b1;
                  state_q <= StPass;
               end
            end
            default: state_q <= StPass;
         endcase
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tvalid = valid_q;
   assign m_axis_tlast  = last_q;

`ifdef PKT_CNT_EN
   logic [15:0] pkt_count_q;

   // Counts packets as their last beat leaves the block; wraps naturally.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_count_q <= 16'h0000;
      end else if (valid_q && m_axis_tready && last_q) begin
         pkt_count_q <= pkt_count_q + 16'd1;
      end
   end

   assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_axis_pkt_checksum.sv
module tb_axis_pkt_checksum;

   logic       aclk;
   logic       aresetn;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tlast;
   logic       s_axis_tready;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tlast;
   logic       m_axis_tready;
   logic       csum_en;
`ifdef PKT_CNT_EN
   logic [15:0] pkt_count;
`endif

   int total = 0;
   int bad   = 0;

   axis_pkt_checksum #(.CSUM_INIT(8'h00)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .csum_en       (csum_en)
`ifdef PKT_CNT_EN
      ,
      .pkt_count     (pkt_count)
`endif
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Bytes are left-aligned: byte i of din is din[63-8*i -: 8], of dout dout[71-8*i -: 8].
   typedef struct {
      int          n_in;
      logic [63:0] din;
      bit          en;
      bit          flip;   // invert csum_en after the first accepted beat
      bit          stall;  // random m_axis_tready
      int          n_out;
      logic [71:0] dout;
      int          bub;    // expected cycles with s_axis_tready low (unstalled only)
   } vec_t;

   vec_t vecs[10];

   function automatic vec_t mkv(int ni, logic [63:0] di, bit en, bit fl, bit st,
                                int no, logic [71:0] dout, int bub);
      vec_t v;
      v.n_in = ni; v.din = di; v.en = en; v.flip = fl; v.stall = st;
      v.n_out = no; v.dout = dout; v.bub = bub;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int         idx = 0;
      int         cyc = 0;
      int         tail = 0;
      int         bub = 0;
      bit         prev_stall = 1'b0;
      bit         flip_pend = 1'b0;
      logic [9:0] prev = '0;
      logic [7:0] outb[$];
      logic       outl[$];
      csum_en = v.en;
      while (!(idx == v.n_in && outb.size() >= v.n_out && tail >= 3) && cyc < 300) begin
         @(negedge aclk);
         cyc++;
         if (flip_pend) begin
            csum_en   = ~v.en;
            flip_pend = 1'b0;
         end
         m_axis_tready = (v.stall && outb.size() < v.n_out) ? ($urandom_range(0, 2) != 0) : 1'b1;
         if (idx < v.n_in) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = v.din[63-8*idx -: 8];
            s_axis_tlast  = (idx == v.n_in - 1);
         end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 8'h00;
            s_axis_tlast  = 1'b0;
         end
         #1;
         if (prev_stall)
            chk($sformatf("v%0d stall_hold", id), 32'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                32'(prev));
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev       = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
         if (m_axis_tvalid && m_axis_tready) begin
            outb.push_back(m_axis_tdata);
            outl.push_back(m_axis_tlast);
         end
         if (!s_axis_tready) bub++;
         if (idx < v.n_in) begin
            if (s_axis_tready) begin
               idx++;
               if (v.flip && idx == 1) flip_pend = 1'b1;
            end
         end else if (outb.size() >= v.n_out) begin
            tail++;
         end
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      chk($sformatf("v%0d timeout", id), 32'(cyc < 300), 32'd1);
      chk($sformatf("v%0d beats", id), 32'(outb.size()), 32'(v.n_out));
      for (int i = 0; i < outb.size() && i < v.n_out; i++)
         chk($sformatf("v%0d beat%0d {last,data}", id, i), 32'({outl[i], outb[i]}),
             32'({(i == v.n_out - 1), v.dout[71-8*i -: 8]}));
      if (!v.stall)
         chk($sformatf("v%0d ready_low_cycles", id), 32'(bub), 32'(v.bub));
   endtask

   initial begin
      int idx;
      int cyc;
      vecs[0] = mkv(3, 64'h01_02_03_00_00_00_00_00, 1, 0, 0, 4, 72'h01_02_03_FA_00_00_00_00_00, 1);
      vecs[1] = mkv(1, 64'h00_00_00_00_00_00_00_00, 1, 0, 0, 2, 72'h00_00_00_00_00_00_00_00_00, 1);
      vecs[2] = mkv(2, 64'h10_20_00_00_00_00_00_00, 0, 0, 0, 2, 72'h10_20_00_00_00_00_00_00_00, 0);
      vecs[3] = mkv(7, 64'h11_22_33_44_55_66_77_00, 1, 0, 1, 8, 72'h11_22_33_44_55_66_77_24_00, 1);
      vecs[4] = mkv(1, 64'hFF_00_00_00_00_00_00_00, 0, 0, 0, 1, 72'hFF_00_00_00_00_00_00_00_00, 0);
      vecs[5] = mkv(2, 64'h80_80_00_00_00_00_00_00, 1, 0, 0, 3, 72'h80_80_00_00_00_00_00_00_00, 1);
      vecs[6] = mkv(3, 64'hFF_01_02_00_00_00_00_00, 1, 0, 0, 4, 72'hFF_01_02_FE_00_00_00_00_00, 1);
      vecs[7] = mkv(2, 64'h0A_0B_00_00_00_00_00_00, 0, 1, 0, 2, 72'h0A_0B_00_00_00_00_00_00_00, 0);
      vecs[8] = mkv(2, 64'h03_04_00_00_00_00_00_00, 1, 1, 0, 3, 72'h03_04_F9_00_00_00_00_00_00, 1);
      vecs[9] = mkv(5, 64'hA1_B2_C3_D4_E5_00_00_00, 0, 0, 1, 5, 72'hA1_B2_C3_D4_E5_00_00_00_00, 0);

      aresetn       = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      csum_en       = 1'b0;
      repeat (3) @(negedge aclk);
      #1;
      chk("reset m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("reset m_tlast", 32'(m_axis_tlast), 32'd0);
      chk("reset m_tdata", 32'(m_axis_tdata), 32'd0);
      chk("reset s_tready", 32'(s_axis_tready), 32'd1);
`ifdef PKT_CNT_EN
      chk("reset pkt_count", 32'(pkt_count), 32'd0);
`endif
      @(negedge aclk);
      aresetn = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset in the middle of an enabled packet: 3 of 7 bytes, then a pulse.
      csum_en = 1'b1;
      idx = 0;
      cyc = 0;
      while (idx < 3 && cyc < 50) begin
         @(negedge aclk);
         cyc++;
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = 8'h30 + 8'(idx);
         s_axis_tlast  = 1'b0;
         #1;
         if (s_axis_tready) idx++;
      end
      chk("midreset feed timeout", 32'(idx), 32'd3);
      @(negedge aclk);
      chk("midreset valid before", 32'(m_axis_tvalid), 32'd1);
      s_axis_tdata = 8'hEE;
      s_axis_tlast = 1'b1;
      #2;
      aresetn = 1'b0;
      #1;
      chk("midreset m_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("midreset s_tready", 32'(s_axis_tready), 32'd1);
`ifdef PKT_CNT_EN
      chk("midreset pkt_count", 32'(pkt_count), 32'd0);
`endif
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      aresetn       = 1'b1;
      #1;
      chk("after reset m_tvalid", 32'(m_axis_tvalid), 32'd0);
      run_vec(mkv(1, 64'h05_00_00_00_00_00_00_00, 1, 0, 0, 2, 72'h05_FB_00_00_00_00_00_00_00, 1),
              10);
      run_vec(vecs[0], 11);
      run_vec(vecs[1], 12);
`ifdef PKT_CNT_EN
      #1;
      chk("pkt_count after 3", 32'(pkt_count), 32'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
